// File: rtl/alu_power_sched.sv
// Front-end controller for the power-gated 4-bit ALU domain: round-robin
// request arbitration, tagged result return and power-domain sequencing.
module alu_power_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDLE_CYCLES = 5,
  parameter int unsigned WAKE_CYCLES = 3,
  parameter int unsigned ISO_CYCLES  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [4*NUM_REQ-1:0]       req_a,
  input  logic [4*NUM_REQ-1:0]       req_b,
  input  logic [3*NUM_REQ-1:0]       req_op,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  output logic [2:0]                 alu_op,
  input  logic [3:0]                 alu_result,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [3:0]                 rsp_data,
  output logic                       pwr_en,
  output logic                       iso_en,
  output logic                       clk_en,
  output logic [1:0]                 state
);

  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned T_MAX  = (WAKE_CYCLES > ISO_CYCLES) ? WAKE_CYCLES : ISO_CYCLES;
  localparam int unsigned T_W    = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2,
    ISO  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [T_W-1:0]      timer_q, timer_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [ID_W-1:0]     ptr_q;
  logic                inflight_q;
  logic [ID_W-1:0]     inflight_id_q;

  logic                any_valid;
  logic                found;
  logic                accept;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W:0]       sum;
  logic [ID_W-1:0]     cand;
  logic [3:0]          sel_a, sel_b;
  logic [2:0]          sel_op;
  logic                pwr_d, iso_d, clk_d;

  assign any_valid = |req_valid;
  assign state     = state_q;

  // Round-robin search upward from ptr+1 with wrap-around
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      cand = ID_W'(sum);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign accept = (state_q == RUN) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        sel_a  = req_a[i*4 +: 4];
        sel_b  = req_b[i*4 +: 4];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  // Power sequencing next-state and registered domain controls
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pwr_d   = 1'b0;
    iso_d   = 1'b1;
    clk_d   = 1'b0;
    case (state_q)
      OFF: begin
        if (any_valid) begin
          state_d = WAKE;
          timer_d = '0;
        end
      end
      WAKE: begin
        if (timer_q == T_W'(WAKE_CYCLES - 1)) begin
          state_d = RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_W'(1);
        end
      end
      RUN: begin
        if ((idle_q == IDLE_W'(IDLE_CYCLES)) && !any_valid && !inflight_q) begin
          state_d = ISO;
          timer_d = '0;
        end
      end
      ISO: begin
        if (any_valid) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == T_W'(ISO_CYCLES - 1)) begin
          state_d = OFF;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
    case (state_d)
      WAKE:    begin pwr_d = 1'b1; iso_d = 1'b1; clk_d = 1'b0; end
      RUN:     begin pwr_d = 1'b1; iso_d = 1'b0; clk_d = 1'b1; end
      ISO:     begin pwr_d = 1'b1; iso_d = 1'b1; clk_d = 1'b0; end
      default: begin pwr_d = 1'b0; iso_d = 1'b1; clk_d = 1'b0; end
    endcase
  end

  // Idle counter: only true idle RUN cycles count, saturating
  always_comb begin
    idle_d = idle_q;
    if ((state_q != RUN) || accept) begin
      idle_d = '0;
    end else if (!inflight_q && (idle_q != IDLE_W'(IDLE_CYCLES))) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OFF;
      timer_q <= '0;
      idle_q  <= '0;
      pwr_en  <= 1'b0;
      iso_en  <= 1'b1;
      clk_en  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idle_q  <= idle_d;
      pwr_en  <= pwr_d;
      iso_en  <= iso_d;
      clk_en  <= clk_d;
    end
  end

  // Issue stage and one-cycle-later result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q         <= ID_W'(NUM_REQ - 1);
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_data      <= '0;
    end else begin
      inflight_q <= accept;
      rsp_valid  <= inflight_q;
      if (accept) begin
        ptr_q         <= gnt_idx;
        inflight_id_q <= gnt_idx;
        alu_a         <= sel_a;
        alu_b         <= sel_b;
        alu_op        <= sel_op;
      end
      if (inflight_q) begin
        rsp_id   <= inflight_id_q;
        rsp_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_power_sched.sv
// Directed bench for alu_power_sched with a behavioural 4-bit ALU in the loop.
module tb_alu_power_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [11:0] req_op;
  logic [3:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [3:0]  alu_result;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        pwr_en, iso_en, clk_en;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  alu_power_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .pwr_en(pwr_en), .iso_en(iso_en), .clk_en(clk_en), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: add, sub, and, or, xor, shift-left-by-one
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = {alu_a[2:0], 1'b0};
      default: alu_result = 4'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_fields(input int i, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op);
    req_a[i*4 +: 4]  = a;
    req_b[i*4 +: 4]  = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic chk_pwr(input string tag, input logic [1:0] st, input logic p,
                         input logic iso, input logic ce);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_pwr"}, 32'(pwr_en), 32'(p));
    chk({tag, "_iso"}, 32'(iso_en), 32'(iso));
    chk({tag, "_clken"}, 32'(clk_en), 32'(ce));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    smp();
    chk_pwr("rst", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    adv();

    // 20 idle cycles stay OFF
    for (int i = 0; i < 20; i++) begin
      smp();
      chk("idle_off_state", 32'(state), 0);
      chk("idle_off_rsp", 32'(rsp_valid), 0);
      chk("idle_off_ready", 32'(req_ready), 0);
      adv();
    end

    // Wake from OFF with req0: 3+5 add
    set_fields(0, 4'd3, 4'd5, 3'b000);
    req_valid = 4'b0001;
    smp();
    chk("wk_off_state", 32'(state), 0);
    chk("wk_off_ready", 32'(req_ready), 0);
    adv();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk_pwr("wake", 2'd1, 1'b1, 1'b1, 1'b0);
      chk("wake_ready", 32'(req_ready), 0);
      adv();
    end
    smp();
    chk_pwr("run1", 2'd2, 1'b1, 1'b0, 1'b1);
    chk("run1_ready", 32'(req_ready), 32'h1);
    adv();
    req_valid = '0;
    smp();
    chk("op1_alu_a", 32'(alu_a), 3);
    chk("op1_alu_b", 32'(alu_b), 5);
    chk("op1_rsp_early", 32'(rsp_valid), 0);
    adv();
    smp();
    chk("op1_rsp_valid", 32'(rsp_valid), 1);
    chk("op1_rsp_id", 32'(rsp_id), 0);
    chk("op1_rsp_data", 32'(rsp_data), 8);
    adv();
    smp();
    chk("op1_rsp_pulse", 32'(rsp_valid), 0);
    chk("op1_rsp_hold", 32'(rsp_data), 8);
    adv();

    // Idle power-down: 5 idle RUN cycles after the response, ISO, then OFF
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("pd_run_state", 32'(state), 2);
      adv();
    end
    smp();
    chk_pwr("pd_iso", 2'd3, 1'b1, 1'b1, 1'b0);
    adv();
    smp();
    chk_pwr("pd_off", 2'd0, 1'b0, 1'b1, 1'b0);
    adv();

    // Reset pointer, then three requesters held valid
    reset = 1'b1;
    adv();
    reset = 1'b0;
    set_fields(0, 4'd9, 4'd4, 3'b001);
    set_fields(1, 4'd12, 4'd10, 3'b010);
    set_fields(2, 4'd5, 4'd0, 3'b101);
    req_valid = 4'b0111;
    adv();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rr_wake_state", 32'(state), 1);
      adv();
    end
    smp();
    chk("rr_g0", 32'(req_ready), 32'h1);
    adv();
    smp();
    chk("rr_g1", 32'(req_ready), 32'h2);
    chk("rr_noresp", 32'(rsp_valid), 0);
    adv();
    smp();
    chk("rr_g2", 32'(req_ready), 32'h4);
    chk("rr_r0_valid", 32'(rsp_valid), 1);
    chk("rr_r0_id", 32'(rsp_id), 0);
    chk("rr_r0_data", 32'(rsp_data), 5);
    adv();
    smp();
    chk("rr_g3", 32'(req_ready), 32'h1);
    chk("rr_r1_valid", 32'(rsp_valid), 1);
    chk("rr_r1_id", 32'(rsp_id), 1);
    chk("rr_r1_data", 32'(rsp_data), 8);
    adv();
    req_valid = '0;
    smp();
    chk("rr_ready_off", 32'(req_ready), 0);
    chk("rr_r2_valid", 32'(rsp_valid), 1);
    chk("rr_r2_id", 32'(rsp_id), 2);
    chk("rr_r2_data", 32'(rsp_data), 10);
    adv();
    smp();
    chk("rr_r3_valid", 32'(rsp_valid), 1);
    chk("rr_r3_id", 32'(rsp_id), 0);
    chk("rr_r3_data", 32'(rsp_data), 5);
    adv();

    // Idle again, then a request lands during ISO
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("iso2_run_state", 32'(state), 2);
      adv();
    end
    req_valid = 4'b0010;
    smp();
    chk_pwr("iso2", 2'd3, 1'b1, 1'b1, 1'b0);
    chk("iso2_ready", 32'(req_ready), 0);
    adv();
    smp();
    chk_pwr("iso2_run", 2'd2, 1'b1, 1'b0, 1'b1);
    chk("iso2_g1", 32'(req_ready), 32'h2);
    adv();
    req_valid = '0;
    smp();
    chk("iso2_noresp", 32'(rsp_valid), 0);
    adv();
    smp();
    chk("iso2_rsp_valid", 32'(rsp_valid), 1);
    chk("iso2_rsp_id", 32'(rsp_id), 1);
    chk("iso2_rsp_data", 32'(rsp_data), 8);
    adv();

    // Reset the cycle after a handshake discards the op
    req_valid = 4'b0001;
    smp();
    chk("rsthx_ready", 32'(req_ready), 32'h1);
    adv();
    req_valid = '0;
    reset = 1'b1;
    smp();
    chk_pwr("rsthx", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("rsthx_rsp", 32'(rsp_valid), 0);
    chk("rsthx_alu_a", 32'(alu_a), 0);
    chk("rsthx_alu_op", 32'(alu_op), 0);
    chk("rsthx_rsp_data", 32'(rsp_data), 0);
    adv();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("post_rst_rsp", 32'(rsp_valid), 0);
      chk("post_rst_state", 32'(state), 0);
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
